// File: rtl/pc_issue_seq.sv
// pc_issue_seq
// Fetch-side issue sequencer for the processor_ring core. Produces the
// stage-0 valid (pc_en) and PC (pc0) consumed by the valid/pc/control
// pipeline, reacts to early (br) and commit-stage (br_c) redirects by
// reloading the fetch PC and inserting BUBBLES issue-free cycles, and
// supports start/halt with a DEPTH-cycle drain so software sees a clean
// "pipeline empty" completion pulse.
//
// Ports:
//   clk       in   clock, all state changes on posedge
//   r         in   synchronous active-high reset, overrides everything
//   en        in   pipeline advance, state frozen when low (except done)
//   start     in   leave IDLE and begin issuing at the fetch PC
//   halt      in   stop issuing and drain the pipeline
//   br        in   early branch taken (stage 3), target br_tgt
//   br_tgt    in   PC_W-bit target for br
//   br_c      in   commit-stage branch taken (stage 5), target br_c_tgt
//   br_c_tgt  in   PC_W-bit target for br_c
//   pc_en     out  stage-0 valid, registered
//   pc0       out  stage-0 PC, registered
//   busy      out  sequencer is not IDLE
//   done      out  one-cycle pulse when a drain completes
//   issue_cnt out  wrapping count of issued instructions
module pc_issue_seq #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 6,
    parameter int              BUBBLES  = 1,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             start,
    input  logic             halt,
    input  logic             br,
    input  logic [PC_W-1:0]  br_tgt,
    input  logic             br_c,
    input  logic [PC_W-1:0]  br_c_tgt,
    output logic             pc_en,
    output logic [PC_W-1:0]  pc0,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issue_cnt
);

    // Counters only ever hold BUBBLES-1 and DEPTH-1, so size them for that.
    localparam int BW = (BUBBLES > 1) ? $clog2(BUBBLES) : 1;
    localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REDIRECT,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  pc0_q, pc0_d;
    logic             pc_en_q, pc_en_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [BW-1:0]    bubble_cnt_q, bubble_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;

    logic             redir;
    logic [PC_W-1:0]  redir_tgt;
    logic             issue;

    // The commit-stage branch belongs to an older instruction than the
    // early branch, so its target wins when both fire together.
    assign redir     = br | br_c;
    assign redir_tgt = br_c ? br_c_tgt : br_tgt;

    // Next-state logic. Nothing moves unless en is high, with the single
    // exception of done, which is a pulse and must drop on the following
    // edge even while the pipeline is stalled. halt beats a redirect for
    // the state change, but the redirect target is still captured so a
    // later start resumes at the correct PC. The last bubble edge both
    // returns to RUN and issues, so the first issued PC is the target.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc0_d        = pc0_q;
        pc_en_d      = pc_en_q;
        done_d       = 1'b0;
        issue_cnt_d  = issue_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        issue        = 1'b0;

        if (en) begin
            pc_en_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN, REDIRECT: begin
                    if (redir) begin
                        fetch_pc_d = redir_tgt;
                    end
                    if (halt) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DW'(DEPTH - 1);
                    end else if (redir) begin
                        state_d      = REDIRECT;
                        bubble_cnt_d = BW'(BUBBLES - 1);
                    end else if (state_q == RUN) begin
                        issue = 1'b1;
                    end else if (bubble_cnt_q == '0) begin
                        state_d = RUN;
                        issue   = 1'b1;
                    end else begin
                        bubble_cnt_d = bubble_cnt_q - BW'(1);
                    end
                end
                DRAIN: begin
                    if (redir) begin
                        fetch_pc_d = redir_tgt;
                    end
                    if (drain_cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (issue) begin
                pc_en_d     = 1'b1;
                pc0_d       = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + PC_W'(1);
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pc0_q        <= RESET_PC;
            pc_en_q      <= 1'b0;
            done_q       <= 1'b0;
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pc0_q        <= pc0_d;
            pc_en_q      <= pc_en_d;
            done_q       <= done_d;
            issue_cnt_q  <= issue_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign pc_en     = pc_en_q;
    assign pc0       = pc0_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pc_issue_seq.sv
// tb_pc_issue_seq
// Drives two pc_issue_seq instances with identical stimulus: instance 0
// uses the default parameters (RESET_PC=00, BUBBLES=1, DEPTH=6) and
// instance 1 uses RESET_PC=FE, BUBBLES=2, DEPTH=3 to exercise PC wrap and
// longer bubbles. A behavioural model per instance predicts every output
// on every cycle; directed scenarios add literal expectations, followed
// by a randomized phase.
module tb_pc_issue_seq;

    localparam int M_IDLE   = 0;
    localparam int M_ISSUE  = 1;
    localparam int M_BUBBLE = 2;
    localparam int M_DRAIN  = 3;

    typedef struct packed {
        int          mode;
        logic [7:0]  fetch;
        logic [7:0]  pc0;
        logic        pcEn;
        logic        done;
        logic [15:0] cnt;
        int          waitLeft;
        int          drainLeft;
    } model_t;

    logic       clk;
    logic       rIn, enIn, startIn, haltIn, brIn, brcIn;
    logic [7:0] brTgt, brcTgt;

    logic        pcEnA, pcEnB, busyA, busyB, doneA, doneB;
    logic [7:0]  pc0A, pc0B;
    logic [15:0] cntA, cntB;

    model_t mdl [2];
    bit     checkOn;
    int     checks;
    int     failures;

    pc_issue_seq #(.PC_W(8), .RESET_PC(8'h00), .DEPTH(6), .BUBBLES(1), .CNT_W(16)) dutA (
        .clk(clk), .r(rIn), .en(enIn), .start(startIn), .halt(haltIn),
        .br(brIn), .br_tgt(brTgt), .br_c(brcIn), .br_c_tgt(brcTgt),
        .pc_en(pcEnA), .pc0(pc0A), .busy(busyA), .done(doneA), .issue_cnt(cntA)
    );

    pc_issue_seq #(.PC_W(8), .RESET_PC(8'hFE), .DEPTH(3), .BUBBLES(2), .CNT_W(16)) dutB (
        .clk(clk), .r(rIn), .en(enIn), .start(startIn), .halt(haltIn),
        .br(brIn), .br_tgt(brTgt), .br_c(brcIn), .br_c_tgt(brcTgt),
        .pc_en(pcEnB), .pc0(pc0B), .busy(busyB), .done(doneB), .issue_cnt(cntB)
    );

    // Free-running clock, first rising edge at 5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: waitLeft counts the issue-free edges still
    // owed after a redirect, drainLeft counts edges until the drain ends.
    function automatic model_t stepModel(input model_t m, input logic rI, input logic eI,
                                         input logic sI, input logic hI, input logic bI,
                                         input logic [7:0] bt, input logic bcI,
                                         input logic [7:0] bct, input logic [7:0] rpc,
                                         input int bubbles, input int depth);
        model_t     n;
        logic       redir;
        logic [7:0] tgt;
        logic       doIssue;
        n       = m;
        redir   = bI | bcI;
        tgt     = bcI ? bct : bt;
        doIssue = 1'b0;
        if (rI) begin
            n.mode = M_IDLE; n.fetch = rpc; n.pc0 = rpc; n.pcEn = 1'b0;
            n.done = 1'b0; n.cnt = '0; n.waitLeft = 0; n.drainLeft = 0;
            return n;
        end
        n.done = 1'b0;
        if (!eI) return n;
        if (m.mode == M_IDLE) begin
            if (sI) n.mode = M_ISSUE;
        end else if (m.mode == M_DRAIN) begin
            if (redir) n.fetch = tgt;
            n.drainLeft = m.drainLeft - 1;
            if (n.drainLeft == 0) begin
                n.mode = M_IDLE;
                n.done = 1'b1;
            end
        end else begin
            if (redir) n.fetch = tgt;
            if (hI) begin
                n.mode      = M_DRAIN;
                n.drainLeft = depth;
            end else if (redir) begin
                n.mode     = M_BUBBLE;
                n.waitLeft = bubbles;
            end else if (m.mode == M_ISSUE) begin
                doIssue = 1'b1;
            end else begin
                n.waitLeft = m.waitLeft - 1;
                if (n.waitLeft == 0) begin
                    n.mode  = M_ISSUE;
                    doIssue = 1'b1;
                end
            end
        end
        n.pcEn = doIssue;
        if (doIssue) begin
            n.pc0   = m.fetch;
            n.fetch = m.fetch + 8'd1;
            n.cnt   = m.cnt + 16'd1;
        end
        return n;
    endfunction

    // Advance both models on each rising edge from the inputs that the
    // DUTs are sampling on that same edge.
    always @(posedge clk) begin
        mdl[0] = stepModel(mdl[0], rIn, enIn, startIn, haltIn, brIn, brTgt, brcIn, brcTgt,
                           8'h00, 1, 6);
        mdl[1] = stepModel(mdl[1], rIn, enIn, startIn, haltIn, brIn, brTgt, brcIn, brcTgt,
                           8'hFE, 2, 3);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against its model on each falling edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("A.pc_en", 32'(pcEnA), 32'(mdl[0].pcEn));
            checkOutput("A.pc0", 32'(pc0A), 32'(mdl[0].pc0));
            checkOutput("A.busy", 32'(busyA), 32'(mdl[0].mode != M_IDLE));
            checkOutput("A.done", 32'(doneA), 32'(mdl[0].done));
            checkOutput("A.issue_cnt", 32'(cntA), 32'(mdl[0].cnt));
            checkOutput("B.pc_en", 32'(pcEnB), 32'(mdl[1].pcEn));
            checkOutput("B.pc0", 32'(pc0B), 32'(mdl[1].pc0));
            checkOutput("B.busy", 32'(busyB), 32'(mdl[1].mode != M_IDLE));
            checkOutput("B.done", 32'(doneB), 32'(mdl[1].done));
            checkOutput("B.issue_cnt", 32'(cntB), 32'(mdl[1].cnt));
        end
    end

    // Drive one cycle of inputs, then return just after the following
    // falling edge so the outputs of that rising edge are visible.
    task automatic applyStimulus(input logic rI, input logic eI, input logic sI, input logic hI,
                                 input logic bI, input logic [7:0] bt,
                                 input logic bcI, input logic [7:0] bct);
        rIn = rI; enIn = eI; startIn = sI; haltIn = hI;
        brIn = bI; brTgt = bt; brcIn = bcI; brcTgt = bct;
        @(negedge clk);
    endtask

    task automatic step();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Directed scenarios with hand-computed expectations, then random.
    initial begin
        checks = 0; failures = 0; checkOn = 1'b0;
        rIn = 1'b1; enIn = 1'b0; startIn = 1'b0; haltIn = 1'b0;
        brIn = 1'b0; brTgt = '0; brcIn = 1'b0; brcTgt = '0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("rst.A.pc0", 32'(pc0A), 32'h00);
        checkOutput("rst.A.pc_en", 32'(pcEnA), 32'h0);
        checkOutput("rst.A.busy", 32'(busyA), 32'h0);
        checkOutput("rst.A.cnt", 32'(cntA), 32'h0);
        checkOutput("rst.B.pc0", 32'(pc0B), 32'hFE);

        // Basic issue: start edge, then four issues 00..03.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("start.A.busy", 32'(busyA), 32'h1);
        checkOutput("start.A.pc_en", 32'(pcEnA), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("basic.A.pc0", 32'(pc0A), 32'(i));
            checkOutput("basic.A.pc_en", 32'(pcEnA), 32'h1);
        end
        checkOutput("basic.A.cnt", 32'(cntA), 32'h4);

        // Early branch to 40 while pc0=03: one bubble, then 40, 41.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00);
        checkOutput("br.A.pc_en", 32'(pcEnA), 32'h0);
        checkOutput("br.A.pc0hold", 32'(pc0A), 32'h03);
        step();
        checkOutput("br.A.tgt", 32'(pc0A), 32'h40);
        checkOutput("br.A.pc_en1", 32'(pcEnA), 32'h1);
        step();
        checkOutput("br.A.next", 32'(pc0A), 32'h41);

        // Simultaneous branches: commit-stage target 80 wins.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 8'h80);
        step();
        checkOutput("both.A.pc0", 32'(pc0A), 32'h80);
        // Again, then a fresh br_c to 90 during the bubble restarts it.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 8'h80);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h90);
        checkOutput("rebub.A.pc_en", 32'(pcEnA), 32'h0);
        step();
        checkOutput("rebub.A.pc0", 32'(pc0A), 32'h90);

        // Stall and wrap on instance B (RESET_PC=FE): en 1,0,0,1,1.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checkOutput("wrap.B.pc0a", 32'(pc0B), 32'hFE);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            checkOutput("stall.B.pc0", 32'(pc0B), 32'hFE);
            checkOutput("stall.B.pc_en", 32'(pcEnB), 32'h1);
            checkOutput("stall.B.cnt", 32'(cntB), 32'h1);
        end
        step();
        checkOutput("wrap.B.pc0b", 32'(pc0B), 32'hFF);
        step();
        checkOutput("wrap.B.pc0c", 32'(pc0B), 32'h00);
        checkOutput("wrap.B.cnt", 32'(cntB), 32'h3);

        // Halt at A pc0=05, br_c to 30 during the drain, then restart.
        for (int i = 0; i < 3; i++) step();
        checkOutput("halt.A.pc0", 32'(pc0A), 32'h05);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("halt.A.pc_en", 32'(pcEnA), 32'h0);
        checkOutput("halt.A.busy", 32'(busyA), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h30);
        for (int i = 0; i < 4; i++) step();
        checkOutput("drain.A.done0", 32'(doneA), 32'h0);
        step();
        checkOutput("drain.A.done1", 32'(doneA), 32'h1);
        checkOutput("drain.A.busy", 32'(busyA), 32'h0);
        step();
        checkOutput("drain.A.doneclr", 32'(doneA), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checkOutput("restart.A.pc0", 32'(pc0A), 32'h30);
        checkOutput("restart.A.pc_en", 32'(pcEnA), 32'h1);

        // Reset while in REDIRECT with en low.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("midrst.A.pc0", 32'(pc0A), 32'h00);
        checkOutput("midrst.A.pc_en", 32'(pcEnA), 32'h0);
        checkOutput("midrst.A.cnt", 32'(cntA), 32'h0);
        checkOutput("midrst.A.busy", 32'(busyA), 32'h0);

        // Randomized traffic checked cycle by cycle against the models.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 299) == 0),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 9) == 0),
                          8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 14) == 0),
                          8'($urandom_range(0, 255)));
        end

        checkOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
